// File: rtl/sieve_host_pkg.sv
// Shared types for the sieve host-side job initiator: FSM states, response
// status codes and the default request-volume limit.
package sieve_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_RANGE   = 2'd2,
    ST_INSANE  = 2'd3
  } status_t;

  localparam int unsigned DEFAULT_MAX_VOLUME = 100;

endpackage

// File: rtl/sieve_watchdog.sv
// BUSY-cycle watchdog: counts enabled cycles, saturating at TIMEOUT_CYCLES, and
// flags the cycle that completes the TIMEOUT_CYCLES-th count (0 disables it).
module sieve_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // Expiry is flagged during the last allowed cycle so the job is abandoned
  // after exactly TIMEOUT_CYCLES cycles of start.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_cnt == LAST);

endmodule

// File: rtl/sieve_job_initiator.sv
// Host-side initiator for the sieve core: accepts a volume request, runs the
// start/finished handshake with timeout and sanity checks, returns a response.
module sieve_job_initiator
  import sieve_host_pkg::*;
#(
  parameter int unsigned MAX_VOLUME     = DEFAULT_MAX_VOLUME,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_volume,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_count,
  output logic [1:0]       resp_status,
  output logic [31:0]      volume,
  output logic             start,
  input  logic             finished,
  input  logic [31:0]      count,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  localparam logic [31:0] MAX_VOL_L = 32'(MAX_VOLUME);

  state_t           r_state, w_state;
  logic [31:0]      r_volume, w_volume;
  logic             r_start, w_start;
  logic [31:0]      r_resp_count, w_resp_count;
  status_t          r_resp_status, w_resp_status;
  logic [CNT_W-1:0] r_jobs_done, w_jobs_done;
  logic             r_pend, w_pend;
  logic [31:0]      r_pend_vol, w_pend_vol;
  logic             w_wd_clear, w_wd_en, w_expired;

  assign w_wd_en    = (r_state == BUSY);
  assign w_wd_clear = (r_state != BUSY);

  sieve_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_volume      <= '0;
      r_start       <= 1'b0;
      r_resp_count  <= '0;
      r_resp_status <= ST_OK;
      r_jobs_done   <= '0;
      r_pend        <= 1'b0;
      r_pend_vol    <= '0;
    end else begin
      r_state       <= w_state;
      r_volume      <= w_volume;
      r_start       <= w_start;
      r_resp_count  <= w_resp_count;
      r_resp_status <= w_resp_status;
      r_jobs_done   <= w_jobs_done;
      r_pend        <= w_pend;
      r_pend_vol    <= w_pend_vol;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_volume      = r_volume;
    w_start       = r_start;
    w_resp_count  = r_resp_count;
    w_resp_status = r_resp_status;
    w_jobs_done   = r_jobs_done;
    w_pend        = r_pend;
    w_pend_vol    = r_pend_vol;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_volume > MAX_VOL_L) begin
            w_resp_count  = '0;
            w_resp_status = ST_RANGE;
            w_state       = RESP;
          end else if (finished) begin
            // Stale finished from an earlier job: hold the request until it clears.
            w_pend     = 1'b1;
            w_pend_vol = req_volume;
            w_state    = DRAIN;
          end else begin
            w_volume = req_volume;
            w_start  = 1'b1;
            w_state  = BUSY;
          end
        end
      end
      BUSY: begin
        if (finished) begin
          w_start       = 1'b0;
          w_resp_count  = count;
          w_resp_status = (count > r_volume) ? ST_INSANE : ST_OK;
          w_state       = RESP;
        end else if (w_expired) begin
          w_start       = 1'b0;
          w_resp_count  = '0;
          w_resp_status = ST_TIMEOUT;
          w_state       = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_jobs_done = r_jobs_done + CNT_W'(1);
          w_state     = finished ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!finished) begin
          if (r_pend) begin
            w_volume = r_pend_vol;
            w_start  = 1'b1;
            w_pend   = 1'b0;
            w_state  = BUSY;
          end else begin
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign busy        = (r_state != IDLE);
  assign resp_count  = r_resp_count;
  assign resp_status = r_resp_status;
  assign volume      = r_volume;
  assign start       = r_start;
  assign jobs_done   = r_jobs_done;

endmodule

// File: tb/tb_sieve_job_initiator.sv
// Bench for sieve_job_initiator: two instances (default watchdog, 64-cycle
// watchdog) driven by a behavioural sieve-core model and a job-level reference.
module tb_sieve_job_initiator;

  localparam int unsigned MAXV = 100;
  localparam int unsigned TO1  = 64;
  localparam logic [1:0] S_OK = 2'd0, S_TO = 2'd1, S_RANGE = 2'd2, S_INSANE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        req_valid[2];
  logic        req_ready[2];
  logic [31:0] req_volume[2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_count[2];
  logic [1:0]  resp_status[2];
  logic [31:0] volume[2];
  logic        start[2];
  logic        finished[2];
  logic [31:0] count[2];
  logic        busy[2];
  logic [15:0] jobs_done[2];

  sieve_job_initiator #(.MAX_VOLUME(MAXV)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_volume(req_volume[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_count(resp_count[0]), .resp_status(resp_status[0]), .volume(volume[0]),
    .start(start[0]), .finished(finished[0]), .count(count[0]), .busy(busy[0]),
    .jobs_done(jobs_done[0])
  );

  sieve_job_initiator #(.MAX_VOLUME(MAXV), .TIMEOUT_CYCLES(TO1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_volume(req_volume[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_count(resp_count[1]), .resp_status(resp_status[1]), .volume(volume[1]),
    .start(start[1]), .finished(finished[1]), .count(count[1]), .busy(busy[1]),
    .jobs_done(jobs_done[1])
  );

  // Sieve core model: finishes after `delay` cycles of start, holds finished
  // until start is low (or longer when `hold` is set).
  bit          core_en[2];
  bit          hold[2];
  bit          fin_force[2];
  bit          core_fin[2];
  int unsigned delay[2];
  logic [31:0] ccount[2];
  int unsigned seen[2];
  int unsigned start_hi[2];

  assign finished[0] = core_fin[0] | fin_force[0];
  assign finished[1] = core_fin[1] | fin_force[1];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (start[d]) begin
        start_hi[d]++;
        if (core_en[d] && !core_fin[d]) begin
          seen[d]++;
          if (seen[d] == delay[d]) begin
            core_fin[d] = 1'b1;
            count[d]    = ccount[d];
          end
        end
      end else begin
        seen[d] = 0;
        if (core_fin[d] && !hold[d]) core_fin[d] = 1'b0;
      end
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_done[2];
  logic [31:0] last_vol[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic finish_job(input int d, input logic [1:0] est, input logic [31:0] ecnt,
                            input int unsigned ehi, input int unsigned hi0,
                            input int unsigned rw, input bit drain, input string tag);
    int unsigned n;
    n = 0;
    while (!resp_valid[d] && n < ehi + 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_valid"}, 32'(resp_valid[d]), 1);
    for (int unsigned i = 0; i < rw; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(resp_valid[d]), 1);
      chk({tag, "_hold_count"}, resp_count[d], ecnt);
    end
    chk({tag, "_count"}, resp_count[d], ecnt);
    chk({tag, "_status"}, 32'(resp_status[d]), 32'(est));
    chk({tag, "_start_cycles"}, start_hi[d] - hi0, ehi);
    chk({tag, "_start_low"}, 32'(start[d]), 0);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    exp_done[d]++;
    chk({tag, "_jobs_done"}, 32'(jobs_done[d]), exp_done[d] % 65536);
    chk({tag, "_valid_drop"}, 32'(resp_valid[d]), 0);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), drain ? 0 : 1);
  endtask

  task automatic run_job(input int d, input logic [31:0] vol, input int unsigned dly,
                         input logic [31:0] cnt, input bit never, input int unsigned rw,
                         input string tag);
    int unsigned to, hi0, ehi, n;
    logic [1:0]  est;
    logic [31:0] ecnt;
    bit          legal;
    to    = (d == 0) ? 65535 : TO1;
    legal = (vol <= MAXV);
    if (!legal) begin
      est = S_RANGE; ecnt = 0; ehi = 0;
    end else if (never || dly > to) begin
      est = S_TO; ecnt = 0; ehi = to;
    end else begin
      est = (cnt > vol) ? S_INSANE : S_OK; ecnt = cnt; ehi = dly;
    end
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_ready"}, 32'(req_ready[d]), 1);
    delay[d]      = dly;
    ccount[d]     = cnt;
    core_en[d]    = !never;
    hi0           = start_hi[d];
    req_volume[d] = vol;
    req_valid[d]  = 1'b1;
    @(negedge clk);
    req_valid[d]  = 1'b0;
    if (legal) begin
      chk({tag, "_start_on"}, 32'(start[d]), 1);
      last_vol[d] = vol;
    end else begin
      chk({tag, "_start_off"}, 32'(start[d]), 0);
    end
    chk({tag, "_volume"}, volume[d], last_vol[d]);
    chk({tag, "_busy_ready"}, 32'(req_ready[d]), 0);
    finish_job(d, est, ecnt, ehi, hi0, rw, 1'b0, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int unsigned rv, rd, rc, rr, hi0, n;
    rst        = '{1'b0, 1'b0};
    req_valid  = '{1'b0, 1'b0};
    resp_ready = '{1'b0, 1'b0};
    req_volume = '{32'd0, 32'd0};
    core_en    = '{1'b1, 1'b1};
    hold       = '{1'b0, 1'b0};
    fin_force  = '{1'b0, 1'b0};
    delay      = '{10, 10};
    ccount     = '{32'd0, 32'd0};
    exp_done   = '{0, 0};
    last_vol   = '{32'd0, 32'd0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_resp_valid", 32'(resp_valid[d]), 0);
      chk("rst_start", 32'(start[d]), 0);
      chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_volume", volume[d], 0);
      chk("rst_count", resp_count[d], 0);
      chk("rst_status", 32'(resp_status[d]), 0);
      chk("rst_jobs_done", 32'(jobs_done[d]), 0);
    end
    rst = '{1'b1, 1'b1};
    @(negedge clk);
    chk("rel_req_ready0", 32'(req_ready[0]), 1);
    chk("rel_req_ready1", 32'(req_ready[1]), 1);

    run_job(0, 100, 500, 25, 1'b0, 0, "t1");
    run_job(0, 101, 5, 0, 1'b0, 0, "t2_range");
    run_job(0, 100, 7, 150, 1'b0, 2, "t4_insane");
    run_job(0, 50, 3, 50, 1'b0, 1, "eq_count");
    run_job(0, 0, 2, 1, 1'b0, 0, "vol0_insane");
    run_job(0, 32'hFFFF_FFFF, 2, 0, 1'b0, 0, "big_range");

    for (int i = 0; i < 12; i++) begin
      rv = $urandom_range(0, 110);
      rd = $urandom_range(1, 30);
      rc = $urandom_range(0, rv + 10);
      rr = $urandom_range(0, 3);
      run_job(0, rv, rd, rc, 1'b0, rr, "rand");
    end

    run_job(1, 50, 0, 0, 1'b1, 0, "t3_timeout");
    run_job(1, 50, 64, 20, 1'b0, 0, "t3_edge_ok");
    run_job(1, 50, 65, 20, 1'b0, 0, "t3_edge_to");

    fin_force[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t3_late_no_resp", 32'(resp_valid[1]), 0);
      chk("t3_late_ready", 32'(req_ready[1]), 1);
    end

    delay[1]      = 5;
    ccount[1]     = 10;
    core_en[1]    = 1'b1;
    hi0           = start_hi[1];
    req_volume[1] = 30;
    req_valid[1]  = 1'b1;
    @(negedge clk);
    req_valid[1]  = 1'b0;
    repeat (3) begin
      chk("stale_no_start", 32'(start[1]), 0);
      chk("stale_busy", 32'(busy[1]), 1);
      chk("stale_not_ready", 32'(req_ready[1]), 0);
      @(negedge clk);
    end
    fin_force[1] = 1'b0;
    @(negedge clk);
    chk("stale_issue_start", 32'(start[1]), 1);
    chk("stale_issue_volume", volume[1], 30);
    last_vol[1] = 30;
    finish_job(1, S_OK, 10, 5, hi0, 0, 1'b0, "stale");

    hold[0]       = 1'b1;
    delay[0]      = 4;
    ccount[0]     = 17;
    core_en[0]    = 1'b1;
    hi0           = start_hi[0];
    req_volume[0] = 60;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    req_valid[0]  = 1'b0;
    last_vol[0]   = 60;
    finish_job(0, S_OK, 17, 4, hi0, 20, 1'b1, "t5");
    repeat (3) begin
      @(negedge clk);
      chk("t5_drain_ready", 32'(req_ready[0]), 0);
      chk("t5_drain_busy", 32'(busy[0]), 1);
    end
    hold[0] = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("t5_idle_ready", 32'(req_ready[0]), 1);

    delay[0]      = 200;
    ccount[0]     = 5;
    req_volume[0] = 80;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    req_valid[0]  = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_busy_start", 32'(start[0]), 1);
    #2 rst[0] = 1'b0;
    #1;
    chk("t6_rst_start", 32'(start[0]), 0);
    chk("t6_rst_valid", 32'(resp_valid[0]), 0);
    chk("t6_rst_busy", 32'(busy[0]), 0);
    chk("t6_rst_jobs", 32'(jobs_done[0]), 0);
    chk("t6_rst_volume", volume[0], 0);
    exp_done[0] = 0;
    last_vol[0] = 0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    run_job(0, 10, 6, 4, 1'b0, 0, "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
